// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the multi-cycle integer divider.
package div_ctrl_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned RESULT_W = 64;
  localparam int unsigned ITER_CNT = 32;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned PR_W     = 65;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // Result payload as handed back to EX: {hi, lo} = {remainder, quotient}.
  typedef struct packed {
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
  } div_result_t;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [DATA_W-1:0] cond_neg(input logic neg,
                                                 input logic [DATA_W-1:0] v);
    return neg ? DATA_W'(~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// EX <-> divider handshake bundle.
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                start_i;
  logic                annul_i;
  logic [RESULT_W-1:0] result_o;
  logic                ready_o;
  logic                stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divider for MIPS32 DIV/DIVU, one quotient bit per cycle.
// Operands are converted to magnitudes at latch time and the signs are
// reapplied once all 32 steps are done.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  div_ctrl_if.slave bus
);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PR_W-1:0]     pr_q, pr_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic                start_ok;
  logic                op1_neg, op2_neg;
  logic [DATA_W-1:0]   op1_mag, op2_mag;
  logic [DATA_W+1:0]   step_diff;
  logic [PR_W-1:0]     pr_step;
  div_result_t         fixed_res;

  // Request qualifier and operand magnitudes for the latch cycle.
  always_comb begin
    start_ok = bus.start_i & ~bus.annul_i;
    op1_neg  = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    op2_neg  = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    op1_mag  = cond_neg(op1_neg, bus.opdata1_i);
    op2_mag  = cond_neg(op2_neg, bus.opdata2_i);
  end

  // One restoring step: trial-subtract the divisor from the shifted remainder.
  // pr_q[64:31] is the remainder already shifted left with the next dividend
  // bit appended; the extra top bit makes the borrow unambiguous.
  always_comb begin
    step_diff = pr_q[PR_W-1:DATA_W-1] - (DATA_W+2)'(dvs_q);
    if (step_diff[DATA_W+1]) begin
      pr_step = {pr_q[PR_W-2:0], 1'b0};
    end else begin
      pr_step = {step_diff[DATA_W:0], pr_q[DATA_W-2:0], 1'b1};
    end
  end

  // Sign fix: quotient negative when signs differ, remainder follows dividend.
  always_comb begin
    fixed_res.quo = cond_neg(neg_quo_q, pr_q[DATA_W-1:0]);
    fixed_res.rem = cond_neg(neg_rem_q, pr_q[2*DATA_W-1:DATA_W]);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pr_d      = pr_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DIV_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_ok) begin
          if (bus.opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            pr_d      = PR_W'(op1_mag);
            dvs_d     = op2_mag;
            neg_quo_d = op1_neg ^ op2_neg;
            neg_rem_d = op1_neg;
            cnt_d     = '0;
            state_d   = DIV_ON;
          end
        end
      end

      DIV_BYZERO: begin
        pr_d     = '0;
        result_d = '0;
        state_d  = DIV_END;
      end

      DIV_ON: begin
        if (bus.annul_i) begin
          ready_d  = 1'b0;
          result_d = '0;
          cnt_d    = '0;
          state_d  = DIV_FREE;
        end else if (cnt_q < CNT_W'(ITER_CNT)) begin
          pr_d  = pr_step;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d = fixed_res;
          cnt_d    = '0;
          state_d  = DIV_END;
        end
      end

      DIV_END: begin
        if (bus.start_i) begin
          ready_d = 1'b1;
        end else begin
          ready_d  = 1'b0;
          result_d = '0;
          state_d  = DIV_FREE;
        end
      end

      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      pr_q      <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pr_q      <= pr_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  // Stall while a divide is accepted or in progress; never during reset.
  always_comb begin
    bus.stallreq_o = ~rst & ((state_q == DIV_BYZERO) ||
                             (state_q == DIV_ON) ||
                             ((state_q == DIV_FREE) && start_ok));
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl against an arithmetic reference model.
module tb_div_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  div_ctrl_if bus ();

  div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // MIPS DIV/DIVU reference: truncating division, remainder follows dividend.
  function automatic logic [63:0] ref_div(input logic sgn,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] q32, r32;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q   = sa / sb;
    r   = sa % sb;
    q32 = q[31:0];
    r32 = r[31:0];
    return {r32, q32};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide with start held, measure latency and result, then release.
  task automatic run_div(input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input string name);
    logic [63:0] exp;
    int          exp_lat;
    int          lat;
    bit          stall_bad;
    exp     = ref_div(sgn, a, b);
    exp_lat = (b == 32'd0) ? 2 : 34;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    #1;
    total++;
    if (bus.stallreq_o !== 1'b1) begin
      bad++;
      $display("FAIL %s stall_at_start got=%b exp=1", name, bus.stallreq_o);
    end
    lat       = -1;
    stall_bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.stallreq_o !== logic'(k < exp_lat - 1)) stall_bad = 1'b1;
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = 1'($urandom_range(0, 1));
    end
    total++;
    if (lat != exp_lat) begin
      bad++;
      $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat);
    end
    total++;
    if (stall_bad) begin
      bad++;
      $display("FAIL %s stall_profile got=wrong exp=high_until_end", name);
    end
    total++;
    if (bus.result_o !== exp) begin
      bad++;
      $display("FAIL %s result got=%h exp=%h", name, bus.result_o, exp);
    end
    tick();
    total++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== exp || bus.stallreq_o !== 1'b0) begin
      bad++;
      $display("FAIL %s hold got=%b/%h/%b exp=1/%h/0", name, bus.ready_o,
               bus.result_o, bus.stallreq_o, exp);
    end
    bus.start_i = 1'b0;
    tick();
    total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      bad++;
      $display("FAIL %s release got=%b/%h exp=0/0", name, bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (bus.ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=0", bus.ready_o);
    end
    total++;
    if (bus.result_o !== 64'd0) begin
      bad++;
      $display("FAIL reset_result got=%h exp=0", bus.result_o);
    end
    total++;
    if (bus.stallreq_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall got=%b exp=0", bus.stallreq_o);
    end
    rst         = 1'b0;
    bus.start_i = 1'b0;
    tick();
    total++;
    if (bus.ready_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin
      bad++;
      $display("FAIL idle got=%b/%b exp=0/0", bus.ready_o, bus.stallreq_o);
    end
  endtask

  task automatic test_directed();
    run_div(1'b0, 32'd100, 32'd7, "udiv_100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'h2, "sdiv_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "sdiv_7_m2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_min_m1");
    run_div(1'b0, 32'h1234, 32'd0, "div_by_zero");
    run_div(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "sdiv_m1_m1");
    run_div(1'b0, 32'd5, 32'd9, "udiv_small");
  endtask

  task automatic test_random();
    logic        sgn;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_div(sgn, a, b, "random");
    end
  endtask

  task automatic test_annul();
    int seen;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    total++;
    if (bus.stallreq_o !== 1'b1) begin
      bad++;
      $display("FAIL annul_pre_stall got=%b exp=1", bus.stallreq_o);
    end
    bus.annul_i = 1'b1;
    tick();
    total++;
    if (bus.ready_o !== 1'b0 || bus.stallreq_o !== 1'b0 || bus.result_o !== 64'd0) begin
      bad++;
      $display("FAIL annul_free got=%b/%b/%h exp=0/0/0", bus.ready_o,
               bus.stallreq_o, bus.result_o);
    end
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ready_o !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL annul_no_ready got=%0d exp=0", seen);
    end
    run_div(1'b0, 32'd20, 32'd3, "annul_restart");
  endtask

  task automatic test_reset_mid();
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd7;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    for (int i = 0; i < 21; i++) tick();
    rst = 1'b1;
    tick();
    total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0 || bus.stallreq_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got=%b/%h/%b exp=0/0/0", bus.ready_o,
               bus.result_o, bus.stallreq_o);
    end
    rst = 1'b0;
    run_div(1'b0, 32'd50, 32'd5, "rst_restart");
  endtask

  task automatic test_back_to_back();
    run_div(1'b0, 32'd100, 32'd7, "b2b_first");
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
